// File: rtl/muldiv_pkg.sv
// Shared types and op codes for the multicycle multiply/divide sequencer.
// Optional signed operation is enabled with MULDIV_SIGNED_EN.
package muldiv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [3:0] OP_MULT = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;

    localparam logic [63:0] DIV0_QUOT = {64{1'b1}};

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             mode,        // 0 = mult, 1 = div
    input  logic [WIDTH:0]   acc,         // product upper half / remainder
    input  logic [WIDTH-1:0] mcand,       // multiplicand / divisor
    input  logic [WIDTH-1:0] mplier,      // multiplier / quotient
    output logic [WIDTH:0]   acc_next,
    output logic [WIDTH-1:0] mplier_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;

    always_comb begin
        sum    = acc + (mplier[0] ? {1'b0, mcand} : '0);
        rem_sh = {acc[WIDTH-1:0], mplier[WIDTH-1]};
        // Extra top bit is the borrow of the trial subtraction.
        diff   = {1'b0, rem_sh} - {2'b00, mcand};
        if (!mode) begin
            acc_next    = {1'b0, sum[WIDTH:1]};
            mplier_next = {sum[0], mplier[WIDTH-1:1]};
        end else if (!diff[WIDTH+1]) begin
            acc_next    = diff[WIDTH:0];
            mplier_next = {mplier[WIDTH-2:0], 1'b1};
        end else begin
            acc_next    = rem_sh;
            mplier_next = {mplier[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multicycle mult/div unit with start/busy/done handshake and HI/LO results.
// Define MULDIV_SIGNED_EN for two's complement operands.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     acc_q, acc_nx;
    logic [WIDTH-1:0]   mq_q, mq_nx, dvs_q;
    logic               is_div_q, dz_q;
    logic               op_div, accept, dz_in;
    logic [WIDTH-1:0]   a_mag, b_mag, rem, quot, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;
`ifdef MULDIV_SIGNED_EN
    logic               neg_p_q, neg_r_q;
`endif

    assign op_div = (OP == OP_DIV);
    assign accept = start && ((OP == OP_MULT) || op_div) && (state_q != RUN);
    assign dz_in  = op_div && (In2 == '0);

    always_comb begin
        a_mag = In1;
        b_mag = In2;
`ifdef MULDIV_SIGNED_EN
        if (In1[WIDTH-1]) a_mag = -In1;
        if (In2[WIDTH-1]) b_mag = -In2;
`endif
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mode        (is_div_q),
        .acc         (acc_q),
        .mcand       (dvs_q),
        .mplier      (mq_q),
        .acc_next    (acc_nx),
        .mplier_next (mq_nx)
    );

    always_comb begin
        prod = {acc_q[WIDTH-1:0], mq_q};
        quot = mq_q;
        rem  = acc_q[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
        if (neg_p_q) prod = -prod;
        if (neg_p_q) quot = -quot;
        if (neg_r_q) rem  = -rem;
`endif
        if (dz_q) begin
            res_hi = acc_q[WIDTH-1:0];
            res_lo = DIV0_QUOT[WIDTH-1:0];
        end else if (is_div_q) begin
            res_hi = rem;
            res_lo = quot;
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mq_q        <= '0;
            dvs_q       <= '0;
            is_div_q    <= 1'b0;
            dz_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_p_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            // Results publish on the edge leaving DONE; a start accepted on
            // that same edge must not hide this result's div_by_zero.
            if (state_q == DONE) begin
                hi          <= res_hi;
                lo          <= res_lo;
                done        <= 1'b1;
                div_by_zero <= dz_q;
            end else if (accept) begin
                div_by_zero <= 1'b0;
            end
            case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        is_div_q <= op_div;
                        dz_q     <= dz_in;
                        cnt_q    <= '0;
                        mq_q     <= op_div ? a_mag : b_mag;
                        dvs_q    <= op_div ? b_mag : a_mag;
                        acc_q    <= dz_in ? {1'b0, In1} : '0;
`ifdef MULDIV_SIGNED_EN
                        neg_p_q  <= In1[WIDTH-1] ^ In2[WIDTH-1];
                        neg_r_q  <= In1[WIDTH-1];
`endif
                        state_q  <= dz_in ? DONE : RUN;
                        busy     <= !dz_in;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q <= acc_nx;
                    mq_q  <= mq_nx;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LastIter) begin
                        state_q <= DONE;
                        busy    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed scoreboard bench for muldiv_sequencer (signed cases under MULDIV_SIGNED_EN).
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  OP;
    logic [31:0] In1, In2;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   bcnt = 0;
    exp_t sb_q[$];

    muldiv_sequencer #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .OP          (OP),
        .In1         (In1),
        .In2         (In2),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic signed [63:0] sa, sb, r;
        logic [63:0] ua, ub, u;
        e.dbz = 1'b0;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op == OP_DIV && b == 32'd0) begin
            e.hi  = a;
            e.lo  = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
        end else if (op == OP_MULT) begin
`ifdef MULDIV_SIGNED_EN
            r = sa * sb;
            e.hi = r[63:32];
            e.lo = r[31:0];
`else
            u = ua * ub;
            e.hi = u[63:32];
            e.lo = u[31:0];
`endif
        end else begin
`ifdef MULDIV_SIGNED_EN
            r = sa / sb;
            e.lo = r[31:0];
            r = sa % sb;
            e.hi = r[31:0];
`else
            u = ua / ub;
            e.lo = u[31:0];
            u = ua % ub;
            e.hi = u[31:0];
`endif
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (busy === 1'b1) bcnt++;
    endtask

    // Drives start for one edge; returns 1 time unit after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        start = 1'b1;
        OP    = op;
        In1   = a;
        In2   = b;
        if (push) sb_q.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        In1   = $urandom;
        In2   = $urandom;
        cyc   = 0;
        bcnt  = (busy === 1'b1) ? 1 : 0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
        exp_t e;
        while (done !== 1'b1 && cyc < 80) tick();
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_busy_cycles"}, bcnt, exp_busy);
        if (sb_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_hi"}, hi, e.hi);
            chk({tag, "_lo"}, lo, e.lo);
            chk({tag, "_dbz"}, div_by_zero, e.dbz);
        end
    endtask

    initial begin
        bit saw;
        reset = 1'b1;
        start = 1'b0;
        OP    = 4'b0000;
        In1   = '0;
        In2   = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Unsupported op code leaves the unit idle.
        issue(4'b0000, 32'd3, 32'd4, 1'b0);
        saw = 1'b0;
        repeat (5) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
        end
        chk("bad_op_ignored", saw, 0);

        issue(OP_MULT, 32'd7, 32'd6, 1'b1);
        wait_done("mul_7x6", 33, 32);
        chk("mul_7x6_lo_const", lo, 32'd42);
        tick();
        chk("done_one_pulse", done, 0);

        issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("mul_max", 33, 32);

        issue(OP_DIV, 32'd100, 32'd7, 1'b1);
        wait_done("div_100_7", 33, 32);
        chk("div_100_7_lo_const", lo, 32'd14);
        // Back-to-back start in the done cycle; results must hold until overwritten.
        issue(OP_DIV, 32'd9, 32'd3, 1'b1);
        chk("hold_hi", hi, 32'd2);
        chk("hold_lo", lo, 32'd14);
        wait_done("div_9_3", 33, 32);

        issue(OP_DIV, 32'd5, 32'd0, 1'b1);
        wait_done("div_5_0", 1, 0);
        chk("div0_lo_const", lo, 32'hFFFF_FFFF);
        issue(OP_MULT, 32'd2, 32'd2, 1'b1);
        chk("dbz_cleared", div_by_zero, 0);
        wait_done("mul_2x2", 33, 32);

        // A start during RUN with new operands must be ignored.
        issue(OP_MULT, 32'd3, 32'd4, 1'b1);
        repeat (9) tick();
        start = 1'b1;
        OP    = OP_MULT;
        In1   = 32'd5;
        In2   = 32'd5;
        tick();
        start = 1'b0;
        wait_done("mul_repulse", 33, 32);

        // Reset mid-operation aborts without a done pulse.
        issue(OP_MULT, 32'd3, 32'd4, 1'b0);
        repeat (9) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        #2;
        reset = 1'b0;
        saw = 1'b0;
        repeat (40) begin
            tick();
            if (done === 1'b1) saw = 1'b1;
        end
        chk("abort_no_done", saw, 0);
        issue(OP_MULT, 32'd3, 32'd4, 1'b1);
        wait_done("mul_after_rst", 33, 32);
        chk("mul_after_rst_lo_const", lo, 32'd12);

`ifdef MULDIV_SIGNED_EN
        issue(OP_MULT, -32'sd6, 32'd7, 1'b1);
        wait_done("smul_m6x7", 33, 32);
        chk("smul_lo_const", lo, 32'hFFFF_FFD6);
        issue(OP_DIV, -32'sd7, 32'd2, 1'b1);
        wait_done("sdiv_m7_2", 33, 32);
        chk("sdiv_lo_const", lo, 32'hFFFF_FFFD);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done("sdiv_ovf", 33, 32);
        chk("sdiv_ovf_lo_const", lo, 32'h8000_0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
